// File: rtl/mem_lock_arbiter_pkg.sv
// Shared types for the core-to-main-memory arbiter and its hardware lock table.
package fst_pkg;

  localparam int NUM_CORES = 8;
  localparam int CORE_W    = $clog2(NUM_CORES);
  localparam int ADR_W     = 16;
  localparam int DAT_W     = 16;
  localparam int NUM_LOCKS = 16;
  localparam int LOCK_W    = $clog2(NUM_LOCKS);

  typedef logic [CORE_W-1:0] core_id_t;
  typedef logic [ADR_W-1:0]  adr_t;
  typedef logic [DAT_W-1:0]  dat_t;
  typedef logic [LOCK_W-1:0] lock_id_t;

  typedef struct packed {
    logic     valid;
    core_id_t owner;
  } lock_entry_t;

endpackage

// File: rtl/mem_lock_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr (wrapping modulo N), skipping masked ones.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);

  logic [N-1:0] elig;

  assign elig = req & ~mask;

  always_comb begin
    int idx;
    any    = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      // Explicit wrap keeps non-power-of-2 N correct.
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && elig[idx]) begin
        any    = 1'b1;
        gnt_id = IW'(idx);
      end
    end
    gnt = any ? (N'(1) << gnt_id) : '0;
  end

endmodule

// File: rtl/mem_lock_arbiter.sv
// Arbitrates one main-memory slot per cycle among C cores and serves one lock/unlock
// operation per cycle against an owner-tracked lock table.
module mem_lock_arbiter
  import fst_pkg::*;
#(
  parameter int C  = NUM_CORES,
  parameter int AW = ADR_W,
  parameter int DW = DAT_W,
  parameter int NL = NUM_LOCKS,
  localparam int CW = $clog2(C),
  localparam int LW = $clog2(NL)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [C-1:0]          mem_read_req,
  input  logic [C-1:0]          mem_write_req,
  input  logic [C-1:0][AW-1:0]  mem_read_adr,
  input  logic [C-1:0][AW-1:0]  mem_write_adr,
  input  logic [C-1:0][DW-1:0]  mem_write_dat,
  output logic [C-1:0]          mem_ac,
  output logic [AW-1:0]         mm_read_adr,
  output logic [AW-1:0]         mm_write_adr,
  output logic [DW-1:0]         mm_write_dat,
  output logic                  mm_read,
  output logic                  mm_write,
  input  logic [C-1:0][LW-1:0]  lock_adr,
  input  logic [C-1:0]          lock_en,
  input  logic [C-1:0]          unlock_en,
  output logic [C-1:0]          lock_ac,
  output logic                  lock_err
);

  function automatic logic [CW-1:0] ptr_next(input logic [CW-1:0] id);
    return (int'(id) == C - 1) ? '0 : CW'(id + 1'b1);
  endfunction

  logic [CW-1:0] mem_ptr, lock_ptr;
  lock_entry_t   lock_tbl [NL];

  logic [C-1:0]  mem_gnt, lk_gnt;
  logic [CW-1:0] mem_id, lk_id;
  logic          mem_any, lk_any;

  // The previous cycle's grant/ack is the mask, so no core is served twice in a row.
  rr_arbiter #(.N(C)) u_mem_rr (
    .req    (mem_read_req | mem_write_req),
    .mask   (mem_ac),
    .ptr    (mem_ptr),
    .gnt    (mem_gnt),
    .gnt_id (mem_id),
    .any    (mem_any)
  );

  rr_arbiter #(.N(C)) u_lock_rr (
    .req    (lock_en | unlock_en),
    .mask   (lock_ac),
    .ptr    (lock_ptr),
    .gnt    (lk_gnt),
    .gnt_id (lk_id),
    .any    (lk_any)
  );

  logic        lk_unlock, lk_owned, lk_ack;
  logic [LW-1:0] lk_idx;
  lock_entry_t lk_entry;

  always_comb begin
    lk_unlock = unlock_en[lk_id];
    lk_idx    = lock_adr[lk_id];
    lk_entry  = lock_tbl[lk_idx];
    lk_owned  = lk_entry.valid && (lk_entry.owner == core_id_t'(lk_id));
    // Only a lock request on a lock held by someone else goes unacknowledged.
    lk_ack    = lk_any && (lk_unlock || !lk_entry.valid || lk_owned);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ac       <= '0;
      mm_read_adr  <= '0;
      mm_write_adr <= '0;
      mm_write_dat <= '0;
      mm_read      <= 1'b0;
      mm_write     <= 1'b0;
      mem_ptr      <= '0;
      lock_ac      <= '0;
      lock_err     <= 1'b0;
      lock_ptr     <= '0;
      for (int i = 0; i < NL; i++) lock_tbl[i] <= '0;
    end else begin
      mem_ac   <= mem_gnt;
      mm_read  <= mem_any && mem_read_req[mem_id];
      mm_write <= mem_any && mem_write_req[mem_id];
      if (mem_any) begin
        mm_read_adr  <= mem_read_adr[mem_id];
        mm_write_adr <= mem_write_adr[mem_id];
        mm_write_dat <= mem_write_dat[mem_id];
        mem_ptr      <= ptr_next(mem_id);
      end

      lock_ac <= lk_ack ? lk_gnt : '0;
      // A blocked winner still advances the pointer so other cores are not starved.
      if (lk_any) begin
        lock_ptr <= ptr_next(lk_id);
        if (lk_unlock) begin
          if (lk_owned) lock_tbl[lk_idx].valid <= 1'b0;
          else          lock_err <= 1'b1;
        end else if (!lk_entry.valid) begin
          lock_tbl[lk_idx].valid <= 1'b1;
          lock_tbl[lk_idx].owner <= core_id_t'(lk_id);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Directed scoreboard bench for mem_lock_arbiter: expectations queued per edge, checked after it.
module tb_mem_lock_arbiter;

  localparam int C  = 8;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LW = 4;

  localparam int S_MEM_AC   = 0;
  localparam int S_LOCK_AC  = 1;
  localparam int S_LOCK_ERR = 2;
  localparam int S_MM_RD    = 3;
  localparam int S_MM_WR    = 4;
  localparam int S_RD_ADR   = 5;
  localparam int S_WR_ADR   = 6;
  localparam int S_WR_DAT   = 7;

  logic                 clk;
  logic                 reset;
  logic [C-1:0]         mem_read_req, mem_write_req;
  logic [C-1:0][AW-1:0] mem_read_adr, mem_write_adr;
  logic [C-1:0][DW-1:0] mem_write_dat;
  logic [C-1:0]         mem_ac;
  logic [AW-1:0]        mm_read_adr, mm_write_adr;
  logic [DW-1:0]        mm_write_dat;
  logic                 mm_read, mm_write;
  logic [C-1:0][LW-1:0] lock_adr;
  logic [C-1:0]         lock_en, unlock_en, lock_ac;
  logic                 lock_err;

  mem_lock_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read_req  (mem_read_req),
    .mem_write_req (mem_write_req),
    .mem_read_adr  (mem_read_adr),
    .mem_write_adr (mem_write_adr),
    .mem_write_dat (mem_write_dat),
    .mem_ac        (mem_ac),
    .mm_read_adr   (mm_read_adr),
    .mm_write_adr  (mm_write_adr),
    .mm_write_dat  (mm_write_dat),
    .mm_read       (mm_read),
    .mm_write      (mm_write),
    .lock_adr      (lock_adr),
    .lock_en       (lock_en),
    .unlock_en     (unlock_en),
    .lock_ac       (lock_ac),
    .lock_err      (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_MEM_AC:   return 32'(mem_ac);
      S_LOCK_AC:  return 32'(lock_ac);
      S_LOCK_ERR: return 32'(lock_err);
      S_MM_RD:    return 32'(mm_read);
      S_MM_WR:    return 32'(mm_write);
      S_RD_ADR:   return 32'(mm_read_adr);
      S_WR_ADR:   return 32'(mm_write_adr);
      S_WR_DAT:   return 32'(mm_write_dat);
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sig), e.val);
    end
  endtask

  task automatic clear_inputs();
    mem_read_req  = '0;
    mem_write_req = '0;
    mem_read_adr  = '0;
    mem_write_adr = '0;
    mem_write_dat = '0;
    lock_adr      = '0;
    lock_en       = '0;
    unlock_en     = '0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;

    // Reset with requests active: nothing may be granted.
    mem_read_req = 8'hFF;
    lock_en      = 8'hFF;
    expect_out("rst0_mem_ac", S_MEM_AC, 0);
    expect_out("rst0_lock_ac", S_LOCK_AC, 0);
    tick();
    expect_out("rst_mem_ac", S_MEM_AC, 0);
    expect_out("rst_lock_ac", S_LOCK_AC, 0);
    expect_out("rst_lock_err", S_LOCK_ERR, 0);
    expect_out("rst_mm_read", S_MM_RD, 0);
    expect_out("rst_mm_write", S_MM_WR, 0);
    expect_out("rst_rd_adr", S_RD_ADR, 0);
    expect_out("rst_wr_adr", S_WR_ADR, 0);
    expect_out("rst_wr_dat", S_WR_DAT, 0);
    tick();
    reset = 1'b0;
    clear_inputs();

    lock_en[3] = 1'b1; lock_adr[3] = 4'd5;
    expect_out("t1_lock_ac3", S_LOCK_AC, 32'h08);
    tick();
    lock_en[3] = 1'b0;
    expect_out("t1_lock_ac_drop", S_LOCK_AC, 0);
    tick();

    // Three cores reading continuously rotate 0,1,2.
    mem_read_req = 8'h07;
    for (int i = 0; i < 3; i++) mem_read_adr[i] = 16'h0100 + 16'(i);
    for (int n = 0; n < 6; n++) begin
      expect_out($sformatf("t2_mem_ac_%0d", n), S_MEM_AC, 32'(1) << (n % 3));
      expect_out($sformatf("t2_rd_adr_%0d", n), S_RD_ADR, 32'h0100 + 32'(n % 3));
      expect_out($sformatf("t2_mm_read_%0d", n), S_MM_RD, 1);
      tick();
    end
    mem_read_req = '0;
    expect_out("t2_idle_mem_ac", S_MEM_AC, 0);
    expect_out("t2_idle_mm_read", S_MM_RD, 0);
    tick();

    // Lone requester is granted every other cycle.
    mem_read_req = 8'h10;
    for (int n = 0; n < 4; n++) begin
      expect_out($sformatf("t3_mem_ac_%0d", n), S_MEM_AC, (n % 2 == 0) ? 32'h10 : 32'h0);
      tick();
    end
    mem_read_req = '0;
    expect_out("t3_idle", S_MEM_AC, 0);
    tick();

    // Lock contention; reset first so lock_ptr starts at 0.
    reset = 1'b1;
    expect_out("t4_rst_lock_ac", S_LOCK_AC, 0);
    tick();
    reset = 1'b0;
    lock_en = 8'h42; lock_adr[1] = 4'd2; lock_adr[6] = 4'd2;
    expect_out("t4_core1_ack", S_LOCK_AC, 32'h02);
    tick();
    lock_en[1] = 1'b0;
    expect_out("t4_core6_blk0", S_LOCK_AC, 0);
    tick();
    expect_out("t4_core6_blk1", S_LOCK_AC, 0);
    tick();
    unlock_en[1] = 1'b1;
    expect_out("t4_core1_unlock", S_LOCK_AC, 32'h02);
    tick();
    unlock_en[1] = 1'b0;
    expect_out("t4_core6_ack", S_LOCK_AC, 32'h40);
    expect_out("t4_no_err", S_LOCK_ERR, 0);
    tick();
    lock_en[6] = 1'b0;
    expect_out("t4_idle", S_LOCK_AC, 0);
    tick();

    // Non-owner unlock: acked, flagged, ownership untouched.
    lock_en[0] = 1'b1; lock_adr[0] = 4'd7;
    expect_out("t5_core0_lock", S_LOCK_AC, 32'h01);
    tick();
    lock_en[0] = 1'b0;
    expect_out("t5_idle0", S_LOCK_AC, 0);
    tick();
    unlock_en[2] = 1'b1; lock_adr[2] = 4'd7;
    expect_out("t5_bad_unlock_ack", S_LOCK_AC, 32'h04);
    expect_out("t5_lock_err", S_LOCK_ERR, 1);
    tick();
    unlock_en[2] = 1'b0;
    expect_out("t5_idle1", S_LOCK_AC, 0);
    expect_out("t5_err_sticky", S_LOCK_ERR, 1);
    tick();
    lock_en[2] = 1'b1;
    expect_out("t5_core2_blocked", S_LOCK_AC, 0);
    tick();
    lock_en[0] = 1'b1;
    expect_out("t5_core0_relock", S_LOCK_AC, 32'h01);
    tick();
    lock_en[0] = 1'b0;
    expect_out("t5_core2_still_blk", S_LOCK_AC, 0);
    tick();
    lock_en[2] = 1'b0;
    expect_out("t5_idle2", S_LOCK_AC, 0);
    tick();

    // Write slot, then shared read+write slot.
    mem_write_req[5] = 1'b1; mem_write_adr[5] = 16'h0040; mem_write_dat[5] = 16'hBEEF;
    expect_out("t6_mem_ac5", S_MEM_AC, 32'h20);
    expect_out("t6_mm_write", S_MM_WR, 1);
    expect_out("t6_mm_read", S_MM_RD, 0);
    expect_out("t6_wr_adr", S_WR_ADR, 32'h0040);
    expect_out("t6_wr_dat", S_WR_DAT, 32'hBEEF);
    tick();
    mem_write_req[5] = 1'b0;
    expect_out("t6_idle_ac", S_MEM_AC, 0);
    expect_out("t6_idle_wr", S_MM_WR, 0);
    expect_out("t6_dat_hold", S_WR_DAT, 32'hBEEF);
    tick();
    mem_read_req[5] = 1'b1; mem_write_req[5] = 1'b1;
    mem_read_adr[5] = 16'h0077; mem_write_adr[5] = 16'h0041; mem_write_dat[5] = 16'h1234;
    expect_out("t6_rw_rd", S_MM_RD, 1);
    expect_out("t6_rw_wr", S_MM_WR, 1);
    expect_out("t6_rw_rd_adr", S_RD_ADR, 32'h0077);
    expect_out("t6_rw_wr_adr", S_WR_ADR, 32'h0041);
    tick();
    mem_read_req[5] = 1'b0; mem_write_req[5] = 1'b0;
    expect_out("t6_rw_idle", S_MEM_AC, 0);
    tick();

    // Reset mid-hold releases core0's lock on idx 7.
    lock_en[2] = 1'b1; lock_adr[2] = 4'd7; mem_write_req[5] = 1'b1;
    expect_out("t7_blocked", S_LOCK_AC, 0);
    tick();
    reset = 1'b1;
    expect_out("t7_rst_lock_ac", S_LOCK_AC, 0);
    expect_out("t7_rst_mem_ac", S_MEM_AC, 0);
    expect_out("t7_rst_err", S_LOCK_ERR, 0);
    expect_out("t7_rst_mm_write", S_MM_WR, 0);
    tick();
    reset = 1'b0;
    expect_out("t7_freed_ack", S_LOCK_AC, 32'h04);
    expect_out("t7_mem_ac5", S_MEM_AC, 32'h20);
    tick();
    clear_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
